// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM with a memory-wait timeout.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes instead of NOP.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       pc_src,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic [2:0] state_o,
  output logic       instr_done,
  output logic       err
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC_R    = 3'd2,
    EXEC_ADDR = 3'd3,
    EXEC_BR   = 3'd4,
    MEM       = 3'd5,
    WB        = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [6:0] op_q, op_d;
  logic       err_q, err_d;

  logic       pc_write_c, ir_write_c, iord_c, mem_req_c, mem_we_c;
  logic       regwrite_c, memtoreg_c, pc_src_c, alusrc_a_c, done_c;
  logic [1:0] alusrc_b_c, aluop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
      op_q    <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    iord_c     = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    regwrite_c = 1'b0;
    memtoreg_c = 1'b0;
    pc_src_c   = 1'b0;
    alusrc_a_c = 1'b0;
    alusrc_b_c = 2'b00;
    aluop_c    = 2'b00;
    done_c     = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req_c  = 1'b1;
        alusrc_b_c = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERROR;
        end
      end
      DECODE: begin
        op_d = opcode;
        if (opcode == OP_R || opcode == OP_I) begin
          state_d = EXEC_R;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = EXEC_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_d = EXEC_BR;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = ERROR;
`else
          done_c  = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      EXEC_R: begin
        alusrc_a_c = 1'b1;
        if (op_q == OP_I) begin
          alusrc_b_c = 2'b10;
        end else begin
          aluop_c = 2'b10;
        end
        state_d = WB;
      end
      EXEC_ADDR: begin
        alusrc_a_c = 1'b1;
        alusrc_b_c = 2'b10;
        state_d    = MEM;
      end
      EXEC_BR: begin
        alusrc_a_c = 1'b1;
        aluop_c    = 2'b01;
        pc_write_c = zero;
        pc_src_c   = zero;
        done_c     = 1'b1;
        state_d    = FETCH;
      end
      MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = (op_q == OP_SW);
        if (mem_ready) begin
          done_c  = (op_q == OP_SW);
          state_d = (op_q == OP_SW) ? FETCH : WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ERROR;
        end
      end
      WB: begin
        regwrite_c = 1'b1;
        memtoreg_c = (op_q == OP_LW);
        done_c     = 1'b1;
        state_d    = FETCH;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  // Counter restarts on every entry into a memory-waiting state.
  always_comb begin
    wait_d = wait_q;
    if (mem_req_c && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
    if (state_d != state_q &&
        (state_d == FETCH || state_d == MEM)) begin
      wait_d = 8'd0;
    end
    err_d = err_q | (state_d == ERROR);
  end

  // Outputs are forced low while reset is held.
  assign pc_write   = pc_write_c & ~reset;
  assign ir_write   = ir_write_c & ~reset;
  assign iord       = iord_c & ~reset;
  assign mem_req    = mem_req_c & ~reset;
  assign mem_we     = mem_we_c & ~reset;
  assign regwrite   = regwrite_c & ~reset;
  assign memtoreg   = memtoreg_c & ~reset;
  assign pc_src     = pc_src_c & ~reset;
  assign alusrc_a   = alusrc_a_c & ~reset;
  assign alusrc_b   = reset ? 2'b00 : alusrc_b_c;
  assign aluop      = reset ? 2'b00 : aluop_c;
  assign instr_done = done_c & ~reset;
  assign state_o    = reset ? 3'd0 : state_q;
  assign err        = err_q & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction cycle expectations
// are built from the instruction class, memory wait counts and zero flag.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_req, mem_we;
  logic       regwrite, memtoreg, pc_src, alusrc_a;
  logic [1:0] alusrc_b, aluop;
  logic [2:0] state_o;
  logic       instr_done, err;

  int vectors = 0;
  int miscompares = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_req(mem_req), .mem_we(mem_we),
    .regwrite(regwrite), .memtoreg(memtoreg), .pc_src(pc_src),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .state_o(state_o), .instr_done(instr_done), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Observation vector: {state,pcw,irw,iord,mreq,mwe,rw,m2r,pcsrc,asa,asb,aop,done,err}
  localparam logic [17:0] PCW   = 18'd1 << 14;
  localparam logic [17:0] IRW   = 18'd1 << 13;
  localparam logic [17:0] IORD  = 18'd1 << 12;
  localparam logic [17:0] MREQ  = 18'd1 << 11;
  localparam logic [17:0] MWE   = 18'd1 << 10;
  localparam logic [17:0] RW    = 18'd1 << 9;
  localparam logic [17:0] M2R   = 18'd1 << 8;
  localparam logic [17:0] PCSRC = 18'd1 << 7;
  localparam logic [17:0] ASA   = 18'd1 << 6;
  localparam logic [17:0] B_4   = 18'd1 << 4;
  localparam logic [17:0] B_IMM = 18'd2 << 4;
  localparam logic [17:0] A_SUB = 18'd1 << 2;
  localparam logic [17:0] A_FN  = 18'd2 << 2;
  localparam logic [17:0] DONE  = 18'd1 << 1;
  localparam logic [17:0] ERR   = 18'd1;

  function automatic logic [17:0] st(input int n);
    return 18'(n) << 15;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  task automatic step(input string tag, input logic rs, input logic mr,
                      input logic z, input logic [6:0] op,
                      input logic [17:0] exp);
    logic [17:0] obs;
    @(negedge clk);
    reset = rs;
    mem_ready = mr;
    zero = z;
    opcode = op;
    #1;
    obs = {state_o, pc_write, ir_write, iord, mem_req, mem_we, regwrite,
           memtoreg, pc_src, alusrc_a, alusrc_b, aluop, instr_done, err};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    step("reset_hold", 1'b1, rb(), rb(), junk(), 18'd0);
    step("reset_hold2", 1'b1, rb(), rb(), junk(), 18'd0);
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++)
      step("fetch_wait", 1'b0, 1'b0, rb(), junk(), st(0) | MREQ | B_4);
    step("fetch_done", 1'b0, 1'b1, rb(), junk(),
         st(0) | MREQ | B_4 | IRW | PCW);
  endtask

  task automatic do_instr(input logic [6:0] op, input logic z,
                          input int fw, input int mw);
    logic sw;
    sw = (op == OP_SW);
    fetch(fw);
    if (op == OP_R || op == OP_I) begin
      step("decode", 1'b0, rb(), rb(), op, st(1));
      step("exec_r", 1'b0, rb(), rb(), junk(),
           st(2) | ASA | ((op == OP_R) ? A_FN : B_IMM));
      step("wb_alu", 1'b0, rb(), rb(), junk(), st(6) | RW | DONE);
    end else if (op == OP_LW || op == OP_SW) begin
      step("decode", 1'b0, rb(), rb(), op, st(1));
      step("exec_addr", 1'b0, rb(), rb(), junk(), st(3) | ASA | B_IMM);
      for (int i = 0; i < mw; i++)
        step("mem_wait", 1'b0, 1'b0, rb(), junk(),
             st(5) | MREQ | IORD | (sw ? MWE : 18'd0));
      step("mem_done", 1'b0, 1'b1, rb(), junk(),
           st(5) | MREQ | IORD | (sw ? (MWE | DONE) : 18'd0));
      if (!sw)
        step("wb_load", 1'b0, rb(), rb(), junk(), st(6) | RW | M2R | DONE);
    end else if (op == OP_BEQ) begin
      step("decode", 1'b0, rb(), rb(), op, st(1));
      step("exec_br", 1'b0, rb(), z, junk(),
           st(4) | ASA | A_SUB | DONE | (z ? (PCW | PCSRC) : 18'd0));
    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
      step("decode_trap", 1'b0, rb(), rb(), op, st(1));
      step("trap_err", 1'b0, rb(), rb(), junk(), st(7) | ERR);
      step("trap_sticky", 1'b0, rb(), rb(), junk(), st(7) | ERR);
      do_reset();
`else
      step("decode_nop", 1'b0, rb(), rb(), op, st(1) | DONE);
`endif
    end
  endtask

  initial begin
    logic [6:0] op;
    int         pick;

    do_reset();

    // Fetch timeout: 16 idle cycles then sticky ERROR.
    for (int i = 0; i < 16; i++)
      step("to_fetch_wait", 1'b0, 1'b0, rb(), junk(), st(0) | MREQ | B_4);
    step("to_fetch_err", 1'b0, 1'b0, rb(), junk(), st(7) | ERR);
    step("to_err_sticky", 1'b0, 1'b1, rb(), junk(), st(7) | ERR);
    step("to_err_sticky2", 1'b0, 1'b1, rb(), OP_R, st(7) | ERR);
    do_reset();

    // Ready on the expiring cycle wins.
    do_instr(OP_R, 1'b0, 15, 0);
    do_instr(OP_R, 1'b0, 0, 0);
    do_instr(OP_I, 1'b0, 0, 0);
    do_instr(OP_LW, 1'b0, 0, 3);
    do_instr(OP_SW, 1'b0, 0, 0);
    do_instr(OP_BEQ, 1'b1, 0, 0);
    do_instr(OP_BEQ, 1'b0, 0, 0);
    do_instr(OP_LW, 1'b0, 1, 15);
    do_instr(7'b1111111, 1'b0, 0, 0);

    // MEM timeout on a load.
    fetch(0);
    step("decode", 1'b0, 1'b0, 1'b0, OP_LW, st(1));
    step("exec_addr", 1'b0, 1'b0, 1'b0, junk(), st(3) | ASA | B_IMM);
    for (int i = 0; i < 16; i++)
      step("to_mem_wait", 1'b0, 1'b0, rb(), junk(), st(5) | MREQ | IORD);
    step("to_mem_err", 1'b0, 1'b0, rb(), junk(), st(7) | ERR);
    do_reset();

    // Reset mid-store aborts the write.
    fetch(0);
    step("decode", 1'b0, 1'b0, 1'b0, OP_SW, st(1));
    step("exec_addr", 1'b0, 1'b0, 1'b0, junk(), st(3) | ASA | B_IMM);
    step("sw_mem_wait", 1'b0, 1'b0, 1'b0, junk(), st(5) | MREQ | IORD | MWE);
    step("sw_abort", 1'b1, 1'b1, 1'b0, junk(), 18'd0);
    step("post_abort", 1'b0, 1'b0, 1'b0, junk(), st(0) | MREQ | B_4);
    step("post_abort_fetch", 1'b0, 1'b1, 1'b0, junk(),
         st(0) | MREQ | B_4 | IRW | PCW);
    step("post_abort_dec", 1'b0, 1'b0, 1'b0, OP_BEQ, st(1));
    step("post_abort_br", 1'b0, 1'b0, 1'b0, junk(), st(4) | ASA | A_SUB | DONE);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        default: begin
          op = junk();
          if (op == OP_R || op == OP_I || op == OP_LW ||
              op == OP_SW || op == OP_BEQ)
            op = 7'b1111111;
        end
      endcase
      do_instr(op, rb(), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
